mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control unit directly upstream of the 64-bit MIPS datapath.
- Consumes op, funct and zero from the datapath; produces every datapath control strobe and mux select, plus memwrite for data memory.
- Moore FSM (outputs decoded from state and instruction fields), one instruction in flight, variable CPI.

Parameters:
- SW, 4, state register width; must hold encodings 0..11.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  6  instr[31:26] from datapath instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag, already width-selected by dtype
- pcen  out  1  PC register enable
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write
- memwrite  out  1  data memory write strobe
- dtype  out  1  1 = 64-bit ALU result, 0 = 32-bit zero-extended
- iord  out  1  0 = PC address, 1 = aluout address
- memtoreg  out  1  register writeback source: 0 = aluout, 1 = data register
- regdst  out  1  destination: 0 = rt, 1 = rd
- alusrca  out  1  0 = PC, 1 = rs register
- alusrcb  out  3  000 = rt, 001 = const 4, 010 = signimm, 011 = signimm<<2, 100 = zeroimm
- pcsrc  out  2  00 = aluresult, 01 = aluout, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- ltype  out  2  00 = full word, 01 = zero-extended byte, 10 = sign-extended byte
- state  out  SW  current state, for debug/trace

Behaviour:
- Supported ops:
  - R-type 000000, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010, dadd 101100, dsub 101110
  - loads: lw 100011, ld 110111, lbu 100100, lb 100000
  - stores: sw 101011, sd 111111
  - branches: beq 000100, bne 000101
  - immediates: addi 001000, daddi 011000, andi 001100, ori 001101
  - jump: j 000010
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BREX 8, IMMEX 9, IMMWB 10, JEX 11.
- Default for any output not listed in a state: 0, except alucontrol = 010.
- FETCH:
  - iord=0, irwrite=1, alusrca=0, alusrcb=001, alucontrol=010, dtype=1, pcsrc=00, pcen=1.
  - Next state: DECODE.
- DECODE: alusrca=0, alusrcb=011, alucontrol=010, dtype=1 (branch target into aluout). Next state by op:
  - loads/stores -> MEMADR
  - R-type with supported funct -> RTYPEEX
  - beq/bne -> BREX
  - imm ops -> IMMEX
  - j -> JEX
  - any other op or funct -> FETCH (NOP, no architectural write)
- MEMADR: alusrca=1, alusrcb=010, alucontrol=010, dtype=1. Next: MEMWR for stores, else MEMRD.
- MEMRD:
  - iord=1; ltype = 01 for lbu, 10 for lb, 00 for lw/ld.
  - Next: MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR: iord=1, memwrite=1. Next: FETCH.
- RTYPEEX:
  - alusrca=1, alusrcb=000; alucontrol from funct.
  - dtype=1 for dadd/dsub, else 0.
  - Next: RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BREX:
  - alusrca=1, alusrcb=000, alucontrol=110, dtype=1, pcsrc=01.
  - pcen = (op==beq) ? zero : ~zero.
  - Next: FETCH.
- IMMEX:
  - alusrca=1.
  - addi/daddi: alusrcb=010, alucontrol=010; dtype=1 only for daddi.
  - andi/ori: alusrcb=100, alucontrol=000/001, dtype=0.
  - Next: IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- JEX: pcsrc=10, pcen=1. Next: FETCH.
- CPI (cycles, FETCH to next FETCH):
  - loads 5
  - R-type, stores, imm 4
  - branch, j 3
  - unsupported 2
- Outputs are purely a function of state, op, funct and zero. No output is registered separately.
- Reset:
  - reset high at any time, including mid-instruction, sets state=FETCH immediately (asynchronous).
  - While reset is held, outputs show FETCH values: pcen=1, irwrite=1, regwrite=0, memwrite=0.
  - The datapath flops are also in reset, so no write takes effect.
  - First rising edge after deassertion performs the FETCH of address 0.
- regwrite and memwrite must never both be 1 in any state.
- memwrite asserts only in MEMWR.
- Illegal state encodings (12..15) go to FETCH on the next edge with all write strobes 0.

Test Plan:
- Reset for 2 cycles, then release with mem[0]=add $3,$1,$2 -> state trace 0,1,6,7,0. regwrite=1 only in cycle 4 with regdst=1; pcen=1 only in cycle 1.
- lb at PC 4 -> trace 0,1,2,3,4, with ltype=10 during MEMRD. memtoreg=1, regwrite=1 in MEMWB.
- beq with zero=1 in BREX -> pcen=1, pcsrc=01. Repeat with zero=0 -> pcen=0. bne with zero=0 -> pcen=1.
- daddi then andi -> dtype=1/alusrcb=010 for daddi IMMEX; dtype=0/alusrcb=100/alucontrol=000 for andi IMMEX.
- op=111111 (sd) vs op=010001 (unsupported) -> sd: trace 0,1,2,5 with memwrite=1 only in state 5. Unsupported: trace 0,1,0 with no regwrite/memwrite.
- Assert reset asynchronously mid-cycle in MEMWR -> state=0 and memwrite=0 before the next clock edge. Fetch resumes after release.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS-64 control unit: Moore FSM that sequences one instruction at a
// time and decodes every datapath strobe and mux select from state, op, funct and zero.
`timescale 1ns/1ps
module mc_controller #(
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    op,
  input  logic [5:0]    funct,
  input  logic          zero,
  output logic          pcen,
  output logic          irwrite,
  output logic          regwrite,
  output logic          memwrite,
  output logic          dtype,
  output logic          iord,
  output logic          memtoreg,
  output logic          regdst,
  output logic          alusrca,
  output logic [2:0]    alusrcb,
  output logic [1:0]    pcsrc,
  output logic [2:0]    alucontrol,
  output logic [1:0]    ltype,
  output logic [SW-1:0] state
);

  localparam logic [SW-1:0] FETCH   = SW'(0);
  localparam logic [SW-1:0] DECODE  = SW'(1);
  localparam logic [SW-1:0] MEMADR  = SW'(2);
  localparam logic [SW-1:0] MEMRD   = SW'(3);
  localparam logic [SW-1:0] MEMWB   = SW'(4);
  localparam logic [SW-1:0] MEMWR   = SW'(5);
  localparam logic [SW-1:0] RTYPEEX = SW'(6);
  localparam logic [SW-1:0] RTYPEWB = SW'(7);
  localparam logic [SW-1:0] BREX    = SW'(8);
  localparam logic [SW-1:0] IMMEX   = SW'(9);
  localparam logic [SW-1:0] IMMWB   = SW'(10);
  localparam logic [SW-1:0] JEX     = SW'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LD    = 6'b110111;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SD    = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_DADDI = 6'b011000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_DADD = 6'b101100;
  localparam logic [5:0] F_DSUB = 6'b101110;

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_next;
  logic          w_isLoad, w_isStore, w_isRtype, w_isBranch, w_isImm, w_isJump;

  assign w_isLoad   = (op == OP_LW) || (op == OP_LD) || (op == OP_LBU) || (op == OP_LB);
  assign w_isStore  = (op == OP_SW) || (op == OP_SD);
  assign w_isBranch = (op == OP_BEQ) || (op == OP_BNE);
  assign w_isImm    = (op == OP_ADDI) || (op == OP_DADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign w_isJump   = (op == OP_J);
  assign w_isRtype  = (op == OP_RTYPE) &&
                      ((funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                       (funct == F_OR) || (funct == F_SLT) || (funct == F_DADD) ||
                       (funct == F_DSUB));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  assign state = r_state;

  // Unsupported instructions fall back to FETCH straight from DECODE, acting as a NOP
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = DECODE;
      DECODE: begin
        if (w_isLoad || w_isStore) w_next = MEMADR;
        else if (w_isRtype)        w_next = RTYPEEX;
        else if (w_isBranch)       w_next = BREX;
        else if (w_isImm)          w_next = IMMEX;
        else if (w_isJump)         w_next = JEX;
        else                       w_next = FETCH;
      end
      MEMADR:  w_next = w_isStore ? MEMWR : MEMRD;
      MEMRD:   w_next = MEMWB;
      RTYPEEX: w_next = RTYPEWB;
      IMMEX:   w_next = IMMWB;
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    dtype      = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 3'b000;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    ltype      = 2'b00;
    case (r_state)
      FETCH: begin
        irwrite = 1'b1;
        alusrcb = 3'b001;
        dtype   = 1'b1;
        pcen    = 1'b1;
      end
      // Branch target is precomputed here so BREX can select it from aluout
      DECODE: begin
        alusrcb = 3'b011;
        dtype   = 1'b1;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
        dtype   = 1'b1;
      end
      MEMRD: begin
        iord = 1'b1;
        if (op == OP_LBU)     ltype = 2'b01;
        else if (op == OP_LB) ltype = 2'b10;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        dtype   = (funct == F_DADD) || (funct == F_DSUB);
        case (funct)
          F_SUB, F_DSUB: alucontrol = 3'b110;
          F_AND:         alucontrol = 3'b000;
          F_OR:          alucontrol = 3'b001;
          F_SLT:         alucontrol = 3'b111;
          default:       alucontrol = 3'b010;
        endcase
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BREX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        dtype      = 1'b1;
        pcsrc      = 2'b01;
        pcen       = (op == OP_BEQ) ? zero : ~zero;
      end
      IMMEX: begin
        alusrca = 1'b1;
        case (op)
          OP_ANDI: begin
            alusrcb    = 3'b100;
            alucontrol = 3'b000;
          end
          OP_ORI: begin
            alusrcb    = 3'b100;
            alucontrol = 3'b001;
          end
          default: begin
            alusrcb = 3'b010;
            dtype   = (op == OP_DADDI);
          end
        endcase
      end
      IMMWB:   regwrite = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: stimulus pushes hand-computed per-cycle
// expectations into a queue, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b000000;
  logic [5:0] funct = 6'b100000;
  logic       zero = 1'b0;
  logic       pcen, irwrite, regwrite, memwrite, dtype, iord, memtoreg, regdst, alusrca;
  logic [2:0] alusrcb, alucontrol;
  logic [1:0] pcsrc, ltype;
  logic [3:0] state;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [7:0]  tag;
    logic [3:0]  st;
    logic [18:0] outs;
  } exp_t;

  exp_t expQ[$];
  int   vecNum = 0;

  // Output vector order: pcen irwrite regwrite memwrite dtype iord memtoreg regdst alusrca | alusrcb | pcsrc | alucontrol | ltype
  localparam logic [18:0] O_FETCH    = {9'b110010000, 3'b001, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] O_DECODE   = {9'b000010000, 3'b011, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] O_MEMADR   = {9'b000010001, 3'b010, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] O_MEMRD_LB = {9'b000001000, 3'b000, 2'b00, 3'b010, 2'b10};
  localparam logic [18:0] O_MEMWB    = {9'b001000100, 3'b000, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] O_MEMWR    = {9'b000101000, 3'b000, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] O_RTEX_ADD = {9'b000000001, 3'b000, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] O_RTWB     = {9'b001000010, 3'b000, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] O_BREX_T   = {9'b100010001, 3'b000, 2'b01, 3'b110, 2'b00};
  localparam logic [18:0] O_BREX_N   = {9'b000010001, 3'b000, 2'b01, 3'b110, 2'b00};
  localparam logic [18:0] O_IMM_DADD = {9'b000010001, 3'b010, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] O_IMM_ANDI = {9'b000000001, 3'b100, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] O_IMMWB    = {9'b001000000, 3'b000, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] O_JEX      = {9'b100000000, 3'b000, 2'b10, 3'b010, 2'b00};

  localparam logic [5:0] R = 6'b000000, LB = 6'b100000, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] DADDI = 6'b011000, ANDI = 6'b001100, SD = 6'b111111, SW = 6'b101011;
  localparam logic [5:0] BAD = 6'b010001, J = 6'b000010, F_ADD = 6'b100000;

  mc_controller #(.SW(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .dtype(dtype), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .ltype(ltype), .state(state)
  );

  always #5 clk = ~clk;

  // Shared comparison point for the monitor and the direct reset checks
  task automatic checkOutput(input string name, input int tag, input logic [31:0] act,
                             input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s (vec %0d): got %0h, required %0h", name, tag, act, req);
    end
  endtask

  // One clock cycle: drive inputs just after the edge and queue what the cycle should show
  task automatic applyStimulus(input logic rst, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input logic [3:0] st, input logic [18:0] outs);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    op    = o;
    funct = f;
    zero  = z;
    vecNum++;
    e.tag  = 8'(vecNum);
    e.st   = st;
    e.outs = outs;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("state", int'(e.tag), 32'(state), 32'(e.st));
      checkOutput("outputs", int'(e.tag),
                  32'({pcen, irwrite, regwrite, memwrite, dtype, iord, memtoreg, regdst,
                       alusrca, alusrcb, pcsrc, alucontrol, ltype}), 32'(e.outs));
      checkOutput("regwrite_and_memwrite", int'(e.tag), 32'(regwrite & memwrite), 32'd0);
    end
  end

  initial begin
    $display("[TB] start");
    applyStimulus(1'b1, R, F_ADD, 1'b0, 4'd0, O_FETCH);
    applyStimulus(1'b1, R, F_ADD, 1'b0, 4'd0, O_FETCH);
    applyStimulus(1'b0, R, F_ADD, 1'b0, 4'd0, O_FETCH);
    // add $3,$1,$2
    applyStimulus(1'b0, R, F_ADD, 1'b0, 4'd1, O_DECODE);
    applyStimulus(1'b0, R, F_ADD, 1'b0, 4'd6, O_RTEX_ADD);
    applyStimulus(1'b0, R, F_ADD, 1'b0, 4'd7, O_RTWB);
    applyStimulus(1'b0, R, F_ADD, 1'b0, 4'd0, O_FETCH);
    // lb
    applyStimulus(1'b0, LB, 6'd0, 1'b0, 4'd1, O_DECODE);
    applyStimulus(1'b0, LB, 6'd0, 1'b0, 4'd2, O_MEMADR);
    applyStimulus(1'b0, LB, 6'd0, 1'b0, 4'd3, O_MEMRD_LB);
    applyStimulus(1'b0, LB, 6'd0, 1'b0, 4'd4, O_MEMWB);
    applyStimulus(1'b0, LB, 6'd0, 1'b0, 4'd0, O_FETCH);
    // beq taken, beq not taken, bne taken
    applyStimulus(1'b0, BEQ, 6'd0, 1'b0, 4'd1, O_DECODE);
    applyStimulus(1'b0, BEQ, 6'd0, 1'b1, 4'd8, O_BREX_T);
    applyStimulus(1'b0, BEQ, 6'd0, 1'b0, 4'd0, O_FETCH);
    applyStimulus(1'b0, BEQ, 6'd0, 1'b1, 4'd1, O_DECODE);
    applyStimulus(1'b0, BEQ, 6'd0, 1'b0, 4'd8, O_BREX_N);
    applyStimulus(1'b0, BEQ, 6'd0, 1'b0, 4'd0, O_FETCH);
    applyStimulus(1'b0, BNE, 6'd0, 1'b1, 4'd1, O_DECODE);
    applyStimulus(1'b0, BNE, 6'd0, 1'b0, 4'd8, O_BREX_T);
    applyStimulus(1'b0, BNE, 6'd0, 1'b0, 4'd0, O_FETCH);
    // daddi then andi
    applyStimulus(1'b0, DADDI, 6'd0, 1'b0, 4'd1, O_DECODE);
    applyStimulus(1'b0, DADDI, 6'd0, 1'b0, 4'd9, O_IMM_DADD);
    applyStimulus(1'b0, DADDI, 6'd0, 1'b0, 4'd10, O_IMMWB);
    applyStimulus(1'b0, DADDI, 6'd0, 1'b0, 4'd0, O_FETCH);
    applyStimulus(1'b0, ANDI, 6'd0, 1'b0, 4'd1, O_DECODE);
    applyStimulus(1'b0, ANDI, 6'd0, 1'b0, 4'd9, O_IMM_ANDI);
    applyStimulus(1'b0, ANDI, 6'd0, 1'b0, 4'd10, O_IMMWB);
    applyStimulus(1'b0, ANDI, 6'd0, 1'b0, 4'd0, O_FETCH);
    // sd, then an unsupported op, then j
    applyStimulus(1'b0, SD, 6'd0, 1'b0, 4'd1, O_DECODE);
    applyStimulus(1'b0, SD, 6'd0, 1'b0, 4'd2, O_MEMADR);
    applyStimulus(1'b0, SD, 6'd0, 1'b0, 4'd5, O_MEMWR);
    applyStimulus(1'b0, SD, 6'd0, 1'b0, 4'd0, O_FETCH);
    applyStimulus(1'b0, BAD, 6'd0, 1'b0, 4'd1, O_DECODE);
    applyStimulus(1'b0, BAD, 6'd0, 1'b0, 4'd0, O_FETCH);
    applyStimulus(1'b0, J, 6'd0, 1'b0, 4'd1, O_DECODE);
    applyStimulus(1'b0, J, 6'd0, 1'b0, 4'd11, O_JEX);
    applyStimulus(1'b0, J, 6'd0, 1'b0, 4'd0, O_FETCH);
    // sw, interrupted by an asynchronous reset in the middle of MEMWR
    applyStimulus(1'b0, SW, 6'd0, 1'b0, 4'd1, O_DECODE);
    applyStimulus(1'b0, SW, 6'd0, 1'b0, 4'd2, O_MEMADR);
    applyStimulus(1'b0, SW, 6'd0, 1'b0, 4'd5, O_MEMWR);
    #5;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_state", vecNum, 32'(state), 32'd0);
    checkOutput("async_reset_memwrite", vecNum, 32'(memwrite), 32'd0);
    checkOutput("async_reset_pcen", vecNum, 32'(pcen), 32'd1);
    checkOutput("async_reset_irwrite", vecNum, 32'(irwrite), 32'd1);
    checkOutput("async_reset_regwrite", vecNum, 32'(regwrite), 32'd0);
    applyStimulus(1'b1, SW, 6'd0, 1'b0, 4'd0, O_FETCH);
    applyStimulus(1'b0, SW, 6'd0, 1'b0, 4'd0, O_FETCH);
    applyStimulus(1'b0, R, F_ADD, 1'b0, 4'd1, O_DECODE);
    applyStimulus(1'b0, R, F_ADD, 1'b0, 4'd6, O_RTEX_ADD);
    repeat (2) @(posedge clk);
    checkOutput("queue_drained", vecNum, 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
